// File: rtl/dcache_pkg.sv
// Shared data-cache geometry and the line-fill FSM state encoding.
// mod_cache and mod_dcache_fill both import this package.
package dcache_pkg;

  localparam int LOG_WIDTH = 7;
  localparam int WORDSIZE  = 64;
  localparam int ADDRSIZE  = 64;
  localparam int BEATS     = (8 << LOG_WIDTH) / WORDSIZE;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_DATA,
    RD_REQ,
    RD_DATA,
    RESP
  } fill_state_e;

endpackage

// File: rtl/mod_line_buf.sv
// One cache line held as BEATS words.
// Supports a whole-line load, a single-word write and a single-word read by beat index.
module mod_line_buf #(
  parameter int WORDSIZE = 64,
  parameter int BEATS    = 16,
  parameter int IDX_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [BEATS*WORDSIZE-1:0] load_data,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [WORDSIZE-1:0]       wr_data,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [WORDSIZE-1:0]       rd_data,
  output logic [BEATS*WORDSIZE-1:0] line
);

  logic [WORDSIZE-1:0] word_q [BEATS];
  logic [WORDSIZE-1:0] word_d [BEATS];

  always_comb begin
    line = '0;
    for (int i = 0; i < BEATS; i++) begin
      word_d[i] = word_q[i];
      if (load) begin
        word_d[i] = load_data[i*WORDSIZE +: WORDSIZE];
      end else if (wr_en && (wr_idx == IDX_W'(i))) begin
        word_d[i] = wr_data;
      end
      line[i*WORDSIZE +: WORDSIZE] = word_q[i];
    end
  end

  assign rd_data = word_q[rd_idx];

  // Line contents are cleared on reset so fill_data and mem_wdata read back as zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BEATS; i++) word_q[i] <= '0;
    end else begin
      for (int i = 0; i < BEATS; i++) word_q[i] <= word_d[i];
    end
  end

endmodule

// File: rtl/mod_dcache_fill.sv
// Data-cache miss handler: writes back a dirty victim line, reads in the missing line
// as a beat burst, then presents the refilled line to the cache.
module mod_dcache_fill #(
  parameter int LOG_WIDTH = dcache_pkg::LOG_WIDTH,
  parameter int WORDSIZE  = dcache_pkg::WORDSIZE,
  parameter int ADDRSIZE  = dcache_pkg::ADDRSIZE,
  parameter int BEATS     = (8 << LOG_WIDTH) / WORDSIZE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       miss_req,
  output logic                       miss_ready,
  input  logic [ADDRSIZE-1:0]        miss_addr,
  input  logic                       victim_dirty,
  input  logic [ADDRSIZE-1:0]        victim_addr,
  input  logic [(8<<LOG_WIDTH)-1:0]  victim_data,
  output logic                       fill_valid,
  input  logic                       fill_ready,
  output logic [ADDRSIZE-1:0]        fill_addr,
  output logic [(8<<LOG_WIDTH)-1:0]  fill_data,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDRSIZE-1:0]        mem_addr,
  input  logic                       mem_gnt,
  output logic                       mem_wvalid,
  input  logic                       mem_wready,
  output logic [WORDSIZE-1:0]        mem_wdata,
  input  logic                       mem_rvalid,
  input  logic [WORDSIZE-1:0]        mem_rdata
);

  import dcache_pkg::*;

  localparam int                  IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0]    LAST_BEAT  = IDX_W'(BEATS - 1);
  localparam logic [ADDRSIZE-1:0] ALIGN_MASK = ~((ADDRSIZE'(1) << LOG_WIDTH) - ADDRSIZE'(1));

  fill_state_e         state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [ADDRSIZE-1:0] miss_addr_q, miss_addr_d;
  logic [ADDRSIZE-1:0] victim_addr_q, victim_addr_d;
  logic                miss_ready_q, miss_ready_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_wvalid_q, mem_wvalid_d;
  logic                fill_valid_q, fill_valid_d;
  logic                buf_load, buf_wr;
  logic [WORDSIZE-1:0] buf_rd_data;

  mod_line_buf #(
    .WORDSIZE (WORDSIZE),
    .BEATS    (BEATS),
    .IDX_W    (IDX_W)
  ) u_line_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .load_data (victim_data),
    .wr_en     (buf_wr),
    .wr_idx    (cnt_q),
    .wr_data   (mem_rdata),
    .rd_idx    (cnt_q),
    .rd_data   (buf_rd_data),
    .line      (fill_data)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    miss_addr_d   = miss_addr_q;
    victim_addr_d = victim_addr_q;
    buf_load      = 1'b0;
    buf_wr        = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_req && miss_ready_q) begin
          miss_addr_d   = miss_addr & ALIGN_MASK;
          victim_addr_d = victim_addr & ALIGN_MASK;
          buf_load      = 1'b1;
          state_d       = victim_dirty ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        if (mem_gnt) begin
          state_d = WB_DATA;
          cnt_d   = '0;
        end
      end
      WB_DATA: begin
        if (mem_wready) begin
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = RD_REQ;
            cnt_d   = '0;
          end
        end
      end
      RD_REQ: begin
        if (mem_gnt) begin
          state_d = RD_DATA;
          cnt_d   = '0;
        end
      end
      RD_DATA: begin
        if (mem_rvalid) begin
          buf_wr = 1'b1;
          cnt_d  = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
            cnt_d   = '0;
          end
        end
      end
      RESP: begin
        if (fill_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    miss_ready_d = (state_d == IDLE);
    mem_req_d    = (state_d == WB_REQ) || (state_d == RD_REQ);
    mem_we_d     = (state_d == WB_REQ) || (state_d == WB_DATA);
    mem_wvalid_d = (state_d == WB_DATA);
    fill_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      miss_addr_q   <= '0;
      victim_addr_q <= '0;
      miss_ready_q  <= 1'b1;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_wvalid_q  <= 1'b0;
      fill_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      miss_addr_q   <= miss_addr_d;
      victim_addr_q <= victim_addr_d;
      miss_ready_q  <= miss_ready_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_wvalid_q  <= mem_wvalid_d;
      fill_valid_q  <= fill_valid_d;
    end
  end

  assign miss_ready = miss_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_wvalid = mem_wvalid_q;
  assign fill_valid = fill_valid_q;
  assign fill_addr  = miss_addr_q;
  assign mem_addr   = mem_we_q ? victim_addr_q : miss_addr_q;
  assign mem_wdata  = mem_wvalid_q ? buf_rd_data : '0;

endmodule
